// File: rtl/usb_sync_eop_detector_if.sv
// usb_sync_eop_detector_if
//   Bit-stream interface between the NRZI decoder and the SYNC/EOP framing
//   detector.
//   - Upstream (master) drives:    Bit_Valid, Data_In, Diff
//   - Detector (slave) returns:    Sync_Out, Pkt_Active, Bit_Count, Eop_Out,
//                                  Err_Eop, Err_Timeout, Bus_Reset
//   MAX_PKT_BITS must match the detector so Bit_Count has the same width.
interface usb_sync_eop_detector_if #(
  parameter int MAX_PKT_BITS = 1100
);
  localparam int CNT_W = $clog2(MAX_PKT_BITS + 1);

  logic             Bit_Valid;
  logic             Data_In;
  logic             Diff;
  logic             Sync_Out;
  logic             Pkt_Active;
  logic [CNT_W-1:0] Bit_Count;
  logic             Eop_Out;
  logic             Err_Eop;
  logic             Err_Timeout;
  logic             Bus_Reset;

  modport master (
    output Bit_Valid, Data_In, Diff,
    input  Sync_Out, Pkt_Active, Bit_Count, Eop_Out, Err_Eop, Err_Timeout, Bus_Reset
  );

  modport slave (
    input  Bit_Valid, Data_In, Diff,
    output Sync_Out, Pkt_Active, Bit_Count, Eop_Out, Err_Eop, Err_Timeout, Bus_Reset
  );
endinterface

// File: rtl/usb_sync_eop_detector.sv
// usb_sync_eop_detector
//   USB receive framing detector. Matches SYNC on decoded bits, counts body
//   bits with a timeout, qualifies EOP (N SE0 bit times followed by J) and
//   flags short SE0 / missing J and long-SE0 bus reset.
// Ports
//   Sync_Eop_Detector_Clk  bit-recovery clock
//   Reset_n                asynchronous reset, active low
//   det_bus (slave)        Bit_Valid/Data_In/Diff in; Sync_Out, Pkt_Active,
//                          Bit_Count, Eop_Out, Err_Eop, Err_Timeout, Bus_Reset out
//   All outputs are registered; pulses last exactly one clock.
module usb_sync_eop_detector #(
  parameter int          SYNC_LEN       = 8,
  parameter logic [15:0] SYNC_PATTERN   = 16'h0080,
  parameter int          EOP_SE0_BITS   = 2,
  parameter int          BUS_RESET_BITS = 16,
  parameter int          MAX_PKT_BITS   = 1100
) (
  input logic                   Sync_Eop_Detector_Clk,
  input logic                   Reset_n,
  usb_sync_eop_detector_if.slave det_bus
);

  localparam int CNT_W  = $clog2(MAX_PKT_BITS + 1);
  localparam int FILL_W = $clog2(SYNC_LEN + 1);
  localparam int SE0_W  = $clog2(BUS_RESET_BITS + 1);
  localparam logic [SYNC_LEN-1:0] PATTERN_C = SYNC_PATTERN[SYNC_LEN-1:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SE0    = 2'd2
  } state_t;

  state_t              state_r,       state_nxt_s;
  logic [SYNC_LEN-1:0] window_r,      window_nxt_s;
  logic [FILL_W-1:0]   fill_r,        fill_nxt_s;
  logic [SE0_W-1:0]    se0_cnt_r,     se0_cnt_nxt_s;
  logic [CNT_W-1:0]    bit_count_r,   bit_count_nxt_s;
  logic                pkt_active_r,  pkt_active_nxt_s;
  logic                bus_reset_r,   bus_reset_nxt_s;
  logic                sync_out_r,    sync_out_nxt_s;
  logic                eop_out_r,     eop_out_nxt_s;
  logic                err_eop_r,     err_eop_nxt_s;
  logic                err_timeout_r, err_timeout_nxt_s;

  logic [SYNC_LEN-1:0] window_shift_s;
  logic [FILL_W-1:0]   fill_inc_s;
  logic [SE0_W-1:0]    se0_inc_s;
  logic                sync_hit_s;
  logic                timeout_s;

  // Shared helpers: shifted window (newest bit at MSB), saturating counters, match/timeout decode
  always_comb begin
    window_shift_s = {det_bus.Data_In, window_r[SYNC_LEN-1:1]};
    if (fill_r == FILL_W'(SYNC_LEN)) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + FILL_W'(1);
    end
    if (se0_cnt_r == SE0_W'(BUS_RESET_BITS)) begin
      se0_inc_s = se0_cnt_r;
    end else begin
      se0_inc_s = se0_cnt_r + SE0_W'(1);
    end
    // Match is evaluated on the window including the bit arriving now
    sync_hit_s = (fill_inc_s == FILL_W'(SYNC_LEN)) && (window_shift_s == PATTERN_C);
    timeout_s  = (bit_count_r == CNT_W'(MAX_PKT_BITS));
  end

  // State and datapath registers
  always_ff @(posedge Sync_Eop_Detector_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      window_r      <= '0;
      fill_r        <= '0;
      se0_cnt_r     <= '0;
      bit_count_r   <= '0;
      pkt_active_r  <= 1'b0;
      bus_reset_r   <= 1'b0;
      sync_out_r    <= 1'b0;
      eop_out_r     <= 1'b0;
      err_eop_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      window_r      <= window_nxt_s;
      fill_r        <= fill_nxt_s;
      se0_cnt_r     <= se0_cnt_nxt_s;
      bit_count_r   <= bit_count_nxt_s;
      pkt_active_r  <= pkt_active_nxt_s;
      bus_reset_r   <= bus_reset_nxt_s;
      sync_out_r    <= sync_out_nxt_s;
      eop_out_r     <= eop_out_nxt_s;
      err_eop_r     <= err_eop_nxt_s;
      err_timeout_r <= err_timeout_nxt_s;
    end
  end

  // Next-state decode; only Bit_Valid cycles move the FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (det_bus.Bit_Valid) begin
          if (!det_bus.Diff) begin
            state_nxt_s = ST_SE0;
          end else if (sync_hit_s) begin
            state_nxt_s = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (det_bus.Bit_Valid) begin
          if (!det_bus.Diff) begin
            state_nxt_s = ST_SE0;
          end else if (timeout_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ACTIVE;
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_SE0: begin
        if (det_bus.Bit_Valid && det_bus.Diff) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SE0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and output next values; pulses default low so they last one clock
  always_comb begin
    window_nxt_s      = window_r;
    fill_nxt_s        = fill_r;
    se0_cnt_nxt_s     = se0_cnt_r;
    bit_count_nxt_s   = bit_count_r;
    pkt_active_nxt_s  = pkt_active_r;
    bus_reset_nxt_s   = bus_reset_r;
    sync_out_nxt_s    = 1'b0;
    eop_out_nxt_s     = 1'b0;
    err_eop_nxt_s     = 1'b0;
    err_timeout_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (det_bus.Bit_Valid) begin
          if (det_bus.Diff) begin
            window_nxt_s = window_shift_s;
            fill_nxt_s   = fill_inc_s;
            if (sync_hit_s) begin
              sync_out_nxt_s   = 1'b1;
              pkt_active_nxt_s = 1'b1;
              bit_count_nxt_s  = '0;
            end else begin
              sync_out_nxt_s = 1'b0;
            end
          end else begin
            // SE0 outside a packet: tracked only for bus reset
            fill_nxt_s    = '0;
            se0_cnt_nxt_s = SE0_W'(1);
          end
        end else begin
          fill_nxt_s = fill_r;
        end
      end
      ST_ACTIVE: begin
        if (det_bus.Bit_Valid) begin
          if (det_bus.Diff) begin
            if (timeout_s) begin
              // Count stays at MAX_PKT_BITS for inspection
              err_timeout_nxt_s = 1'b1;
              pkt_active_nxt_s  = 1'b0;
            end else begin
              bit_count_nxt_s = bit_count_r + CNT_W'(1);
            end
          end else begin
            se0_cnt_nxt_s = SE0_W'(1);
          end
        end else begin
          bit_count_nxt_s = bit_count_r;
        end
      end
      ST_SE0: begin
        if (det_bus.Bit_Valid) begin
          if (!det_bus.Diff) begin
            se0_cnt_nxt_s = se0_inc_s;
            if (se0_inc_s == SE0_W'(BUS_RESET_BITS)) begin
              // Bus reset silently abandons any packet in progress
              bus_reset_nxt_s  = 1'b1;
              pkt_active_nxt_s = 1'b0;
            end else begin
              bus_reset_nxt_s = bus_reset_r;
            end
          end else begin
            bus_reset_nxt_s  = 1'b0;
            pkt_active_nxt_s = 1'b0;
            fill_nxt_s       = '0;
            if (pkt_active_r) begin
              if ((se0_cnt_r >= SE0_W'(EOP_SE0_BITS)) && det_bus.Data_In) begin
                eop_out_nxt_s = 1'b1;
              end else begin
                err_eop_nxt_s = 1'b1;
              end
            end else begin
              eop_out_nxt_s = 1'b0;
            end
          end
        end else begin
          se0_cnt_nxt_s = se0_cnt_r;
        end
      end
      default: begin
        pkt_active_nxt_s = 1'b0;
        bus_reset_nxt_s  = 1'b0;
      end
    endcase
  end

  assign det_bus.Sync_Out    = sync_out_r;
  assign det_bus.Pkt_Active  = pkt_active_r;
  assign det_bus.Bit_Count   = bit_count_r;
  assign det_bus.Eop_Out     = eop_out_r;
  assign det_bus.Err_Eop     = err_eop_r;
  assign det_bus.Err_Timeout = err_timeout_r;
  assign det_bus.Bus_Reset   = bus_reset_r;

endmodule

// File: tb/tb_usb_sync_eop_detector.sv
// tb_usb_sync_eop_detector
//   Table of directed vectors, hand-written multi-cycle sequences and
//   randomized strobes, all checked against a behavioural model that tracks
//   received bits in a queue and packet status in a few flags.
module tb_usb_sync_eop_detector;

  localparam int SYNC_LEN       = 8;
  localparam int EOP_SE0_BITS   = 2;
  localparam int BUS_RESET_BITS = 16;
  localparam int MAX_PKT_BITS   = 1100;

  logic clk;
  logic rst_n;

  usb_sync_eop_detector_if #(.MAX_PKT_BITS(MAX_PKT_BITS)) bus ();

  usb_sync_eop_detector #(
    .SYNC_LEN       (SYNC_LEN),
    .SYNC_PATTERN   (16'h0080),
    .EOP_SE0_BITS   (EOP_SE0_BITS),
    .BUS_RESET_BITS (BUS_RESET_BITS),
    .MAX_PKT_BITS   (MAX_PKT_BITS)
  ) dut (
    .Sync_Eop_Detector_Clk (clk),
    .Reset_n               (rst_n),
    .det_bus               (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- reference model ----------------
  bit [7:0] pattern_v = 8'h80;
  bit       m_bits[$];   // last received idle bits, oldest first
  bit       m_in_pkt;
  bit       m_in_se0;
  int       m_se0;
  int       m_cnt;
  bit       m_br;
  bit       e_sync, e_eop, e_err, e_to;

  task automatic model_reset();
    m_bits.delete();
    m_in_pkt = 1'b0; m_in_se0 = 1'b0; m_se0 = 0; m_cnt = 0; m_br = 1'b0;
    e_sync = 1'b0; e_eop = 1'b0; e_err = 1'b0; e_to = 1'b0;
  endtask

  task automatic model_step(input bit bv, input bit din, input bit diff);
    bit match;
    e_sync = 1'b0; e_eop = 1'b0; e_err = 1'b0; e_to = 1'b0;
    if (bv) begin
      if (m_in_se0) begin
        if (!diff) begin
          m_se0 = (m_se0 + 1 > BUS_RESET_BITS) ? BUS_RESET_BITS : m_se0 + 1;
          if (m_se0 == BUS_RESET_BITS) begin
            m_br = 1'b1;
            m_in_pkt = 1'b0;
          end
        end else begin
          m_br = 1'b0;
          if (m_in_pkt) begin
            if (m_se0 >= EOP_SE0_BITS && din) e_eop = 1'b1;
            else e_err = 1'b1;
          end
          m_in_pkt = 1'b0;
          m_in_se0 = 1'b0;
          m_bits.delete();
        end
      end else if (m_in_pkt) begin
        if (diff) begin
          if (m_cnt + 1 > MAX_PKT_BITS) begin
            e_to = 1'b1;
            m_in_pkt = 1'b0;
          end else begin
            m_cnt++;
          end
        end else begin
          m_in_se0 = 1'b1;
          m_se0 = 1;
        end
      end else begin
        if (diff) begin
          m_bits.push_back(din);
          if (m_bits.size() > SYNC_LEN) void'(m_bits.pop_front());
          match = (m_bits.size() == SYNC_LEN);
          for (int i = 0; i < m_bits.size(); i++)
            if (m_bits[i] != pattern_v[i]) match = 1'b0;
          if (match) begin
            e_sync = 1'b1;
            m_in_pkt = 1'b1;
            m_cnt = 0;
          end
        end else begin
          m_bits.delete();
          m_in_se0 = 1'b1;
          m_se0 = 1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic check_model();
    chk("sync_out",    int'(bus.Sync_Out),    int'(e_sync));
    chk("pkt_active",  int'(bus.Pkt_Active),  int'(m_in_pkt));
    chk("bit_count",   int'(bus.Bit_Count),   m_cnt);
    chk("eop_out",     int'(bus.Eop_Out),     int'(e_eop));
    chk("err_eop",     int'(bus.Err_Eop),     int'(e_err));
    chk("err_timeout", int'(bus.Err_Timeout), int'(e_to));
    chk("bus_reset",   int'(bus.Bus_Reset),   int'(m_br));
  endtask

  // Drive one cycle, let the DUT register it, then compare against the model
  task automatic strobe(input bit bv, input bit din, input bit diff);
    bus.Bit_Valid = bv; bus.Data_In = din; bus.Diff = diff;
    @(posedge clk); #1;
    model_step(bv, din, diff);
    check_model();
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, 1'b1);
    strobe(1'b1, 1'b1, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sync"},  int'(bus.Sync_Out),    0);
    chk({tag, "_pkt"},   int'(bus.Pkt_Active),  0);
    chk({tag, "_cnt"},   int'(bus.Bit_Count),   0);
    chk({tag, "_eop"},   int'(bus.Eop_Out),     0);
    chk({tag, "_erre"},  int'(bus.Err_Eop),     0);
    chk({tag, "_to"},    int'(bus.Err_Timeout), 0);
    chk({tag, "_br"},    int'(bus.Bus_Reset),   0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit bv, din, diff;
    bit e_sync, e_pkt;
    int e_cnt;
    bit e_eop, e_err, e_to, e_br;
  } vec_t;

  vec_t tbl[17];

  task automatic set_vec(input int i, input bit bv, input bit din, input bit diff,
                         input bit es, input bit ep, input int ec,
                         input bit ee, input bit er, input bit et, input bit eb);
    tbl[i].bv = bv; tbl[i].din = din; tbl[i].diff = diff;
    tbl[i].e_sync = es; tbl[i].e_pkt = ep; tbl[i].e_cnt = ec;
    tbl[i].e_eop = ee; tbl[i].e_err = er; tbl[i].e_to = et; tbl[i].e_br = eb;
  endtask

  initial begin
    bus.Bit_Valid = 1'b0; bus.Data_In = 1'b0; bus.Diff = 1'b1;
    rst_n = 1'b0;
    model_reset();

    // SYNC with a gap inside the body, 3 body bits, SE0 gap SE0, J -> EOP
    for (int i = 0; i < 7; i++) set_vec(i, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    set_vec(7,  1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    set_vec(8,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    set_vec(9,  1, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    set_vec(10, 1, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    set_vec(11, 1, 1, 1, 0, 1, 3, 0, 0, 0, 0);
    set_vec(12, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    set_vec(13, 0, 1, 1, 0, 1, 3, 0, 0, 0, 0);
    set_vec(14, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    set_vec(15, 1, 1, 1, 0, 0, 3, 1, 0, 0, 0);
    set_vec(16, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);

    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      strobe(tbl[i].bv, tbl[i].din, tbl[i].diff);
      chk("tbl_sync", int'(bus.Sync_Out),    int'(tbl[i].e_sync));
      chk("tbl_pkt",  int'(bus.Pkt_Active),  int'(tbl[i].e_pkt));
      chk("tbl_cnt",  int'(bus.Bit_Count),   tbl[i].e_cnt);
      chk("tbl_eop",  int'(bus.Eop_Out),     int'(tbl[i].e_eop));
      chk("tbl_erre", int'(bus.Err_Eop),     int'(tbl[i].e_err));
      chk("tbl_to",   int'(bus.Err_Timeout), int'(tbl[i].e_to));
      chk("tbl_br",   int'(bus.Bus_Reset),   int'(tbl[i].e_br));
    end

    // SYNC, 16 body bits, SE0, SE0, J
    send_sync();
    chk("seq1_sync", int'(bus.Sync_Out), 1);
    for (int i = 0; i < 16; i++) strobe(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b1, 1'b1);
    chk("seq1_cnt", int'(bus.Bit_Count), 16);
    chk("seq1_eop", int'(bus.Eop_Out), 1);
    chk("seq1_pkt", int'(bus.Pkt_Active), 0);
    chk("seq1_err", int'(bus.Err_Eop), 0);

    // SYNC, 5 bits, single SE0, J -> short-SE0 error, then a fresh SYNC
    send_sync();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1'b1);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b1, 1'b1);
    chk("seq2_err", int'(bus.Err_Eop), 1);
    chk("seq2_eop", int'(bus.Eop_Out), 0);
    send_sync();
    chk("seq2_resync", int'(bus.Sync_Out), 1);
    chk("seq2_cnt0", int'(bus.Bit_Count), 0);

    // Timeout on body bit MAX_PKT_BITS+1
    for (int i = 0; i < MAX_PKT_BITS; i++) strobe(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    chk("seq3_cnt_max", int'(bus.Bit_Count), MAX_PKT_BITS);
    chk("seq3_no_to", int'(bus.Err_Timeout), 0);
    strobe(1'b1, 1'b1, 1'b1);
    chk("seq3_to", int'(bus.Err_Timeout), 1);
    chk("seq3_cnt", int'(bus.Bit_Count), MAX_PKT_BITS);
    chk("seq3_pkt", int'(bus.Pkt_Active), 0);

    // 20 SE0 strobes in IDLE, then J
    for (int i = 1; i <= 20; i++) begin
      strobe(1'b1, 1'b0, 1'b0);
      chk("seq4_br", int'(bus.Bus_Reset), (i >= BUS_RESET_BITS) ? 1 : 0);
    end
    strobe(1'b1, 1'b1, 1'b1);
    chk("seq4_br_end", int'(bus.Bus_Reset), 0);
    chk("seq4_no_eop", int'(bus.Eop_Out), 0);
    chk("seq4_no_err", int'(bus.Err_Eop), 0);

    // Reset mid-body for one clock, then gaps
    send_sync();
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b1, 1'b1);
    bus.Bit_Valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 1'b0);
    check_all_zero("postrst");

    // Randomized traffic with occasional SYNC injection
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        send_sync();
      end else begin
        strobe(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) != 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
